// File: rtl/cmd_pkg.sv
// Shared definitions for the command scheduler: opcodes, field slices and
// the output FSM state type.
package cmd_pkg;

   localparam int unsigned CMD_W = 8;

   // Command byte layout: [7:6] opcode, [5:0] destination ID.
   localparam int unsigned OP_MSB = 7;
   localparam int unsigned OP_LSB = 6;
   localparam int unsigned ID_MSB = 5;
   localparam int unsigned ID_LSB = 0;

   localparam logic [1:0] OP_STOP = 2'b00;
   localparam logic [1:0] OP_GO   = 2'b01;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } out_state_e;

   function automatic logic [1:0] get_op(input logic [CMD_W-1:0] c);
      return c[OP_MSB:OP_LSB];
   endfunction

endpackage

// File: rtl/cmd_sched_if.sv
// Command scheduler bus: two UART-side sources in, one cmd_control-side
// handshake out, plus status. master = environment, slave = scheduler.
interface cmd_sched_if;
   import cmd_pkg::*;

   logic [CMD_W-1:0] rmt_cmd;
   logic             rmt_rdy;
   logic             clr_rmt_rdy;
   logic [CMD_W-1:0] lcl_cmd;
   logic             lcl_rdy;
   logic             clr_lcl_rdy;
   logic [CMD_W-1:0] cmd;
   logic             cmd_rdy;
   logic             clr_cmd_rdy;
   logic             drop;
   logic             full;

   modport master (
      output rmt_cmd, rmt_rdy, lcl_cmd, lcl_rdy, clr_cmd_rdy,
      input  clr_rmt_rdy, clr_lcl_rdy, cmd, cmd_rdy, drop, full
   );

   modport slave (
      input  rmt_cmd, rmt_rdy, lcl_cmd, lcl_rdy, clr_cmd_rdy,
      output clr_rmt_rdy, clr_lcl_rdy, cmd, cmd_rdy, drop, full
   );

endinterface

// File: rtl/cmd_fifo.sv
// DEPTH x CMD_W circular buffer. Flush wins over push and pop; push while
// full and pop while empty are ignored.
module cmd_fifo
   import cmd_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [CMD_W-1:0] i_wdata,
   output logic [CMD_W-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic [CMD_W-1:0] r_mem [DEPTH];

   logic w_push;
   logic w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_rdata = r_mem[r_rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   // Storage array; no reset needed since count gates every read.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/cmd_sched.sv
// Round-robin command scheduler: accepts one of two sources per edge,
// queues GOs, lets STOP pre-empt and flush, discards invalid opcodes, and
// presents commands one at a time to cmd_control.
module cmd_sched
   import cmd_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   cmd_sched_if.slave bus
);

   out_state_e       r_state;
   out_state_e       w_state_nxt;
   logic [CMD_W-1:0] r_cmd;
   logic [CMD_W-1:0] w_cmd_nxt;
   logic             r_clr_rmt;
   logic             r_clr_lcl;
   logic             r_drop;
   logic             r_last_rmt;

   logic [1:0]       w_rmt_op;
   logic [1:0]       w_lcl_op;
   logic             w_rmt_elig;
   logic             w_lcl_elig;
   logic             w_grant_rmt;
   logic             w_grant_lcl;
   logic             w_acc;
   logic [CMD_W-1:0] w_acc_cmd;
   logic [1:0]       w_acc_op;
   logic             w_is_stop;
   logic             w_is_go;
   logic             w_is_bad;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [CMD_W-1:0] w_head;

   assign w_rmt_op = get_op(bus.rmt_cmd);
   assign w_lcl_op = get_op(bus.lcl_cmd);

   // A source whose clear pulse is in flight is still showing the old byte.
   assign w_rmt_elig = bus.rmt_rdy && !r_clr_rmt && (!w_full || (w_rmt_op != OP_GO));
   assign w_lcl_elig = bus.lcl_rdy && !r_clr_lcl && (!w_full || (w_lcl_op != OP_GO));

   // r_last_rmt=0 after reset, so remote wins the first tie.
   assign w_grant_rmt = w_rmt_elig && (!w_lcl_elig || !r_last_rmt);
   assign w_grant_lcl = w_lcl_elig && !w_grant_rmt;
   assign w_acc       = w_grant_rmt || w_grant_lcl;
   assign w_acc_cmd   = w_grant_rmt ? bus.rmt_cmd : bus.lcl_cmd;
   assign w_acc_op    = get_op(w_acc_cmd);

   assign w_is_stop = w_acc && (w_acc_op == OP_STOP);
   assign w_is_go   = w_acc && (w_acc_op == OP_GO);
   assign w_is_bad  = w_acc && w_acc_op[1];

   // A STOP this edge flushes the queue, so nothing is popped alongside it.
   assign w_pop = (r_state == IDLE) && !w_empty && !w_is_stop;

   cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_is_go),
      .i_pop   (w_pop),
      .i_flush (w_is_stop),
      .i_wdata (w_acc_cmd),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Output FSM next state and presented command; STOP overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_cmd_nxt   = r_cmd;
      if (w_is_stop) begin
         w_state_nxt = PRESENT;
         w_cmd_nxt   = w_acc_cmd;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_pop) begin
                  w_state_nxt = PRESENT;
                  w_cmd_nxt   = w_head;
               end
            end
            PRESENT: if (bus.clr_cmd_rdy) w_state_nxt = GAP;
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Output FSM state and command register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cmd   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cmd   <= w_cmd_nxt;
      end
   end

   // Acceptance pulses and the round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clr_rmt  <= 1'b0;
         r_clr_lcl  <= 1'b0;
         r_drop     <= 1'b0;
         r_last_rmt <= 1'b0;
      end else begin
         r_clr_rmt <= w_grant_rmt;
         r_clr_lcl <= w_grant_lcl;
         r_drop    <= w_is_bad;
         if (w_grant_rmt)      r_last_rmt <= 1'b1;
         else if (w_grant_lcl) r_last_rmt <= 1'b0;
      end
   end

   assign bus.cmd         = r_cmd;
   assign bus.cmd_rdy     = (r_state == PRESENT);
   assign bus.clr_rmt_rdy = r_clr_rmt;
   assign bus.clr_lcl_rdy = r_clr_lcl;
   assign bus.drop        = r_drop;
   assign bus.full        = w_full;

endmodule

// File: tb/tb_cmd_sched.sv
// Directed bench for cmd_sched: hand-computed expectations, sampled 1 ns
// after each rising edge.
module tb_cmd_sched;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   cmd_sched_if u_if ();

   cmd_sched #(
      .DEPTH (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
   endtask

   task automatic send_rmt(input logic [7:0] b);
      u_if.rmt_cmd = b;
      u_if.rmt_rdy = 1'b1;
      tick();
      u_if.rmt_rdy = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      u_if.rmt_cmd     = 8'h00;
      u_if.rmt_rdy     = 1'b0;
      u_if.lcl_cmd     = 8'h00;
      u_if.lcl_rdy     = 1'b0;
      u_if.clr_cmd_rdy = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd", u_if.cmd, 8'h00);
      check("rst_cmd_rdy", u_if.cmd_rdy, 1'b0);
      check("rst_clr_rmt", u_if.clr_rmt_rdy, 1'b0);
      check("rst_clr_lcl", u_if.clr_lcl_rdy, 1'b0);
      check("rst_drop", u_if.drop, 1'b0);
      check("rst_full", u_if.full, 1'b0);
      #3 rst_n = 1'b1;

      // Single remote GO
      u_if.rmt_cmd = 8'h45;
      u_if.rmt_rdy = 1'b1;
      tick();
      check("go_clr_rmt", u_if.clr_rmt_rdy, 1'b1);
      check("go_rdy_early", u_if.cmd_rdy, 1'b0);
      u_if.rmt_rdy = 1'b0;
      tick();
      check("go_clr_rmt_off", u_if.clr_rmt_rdy, 1'b0);
      check("go_rdy", u_if.cmd_rdy, 1'b1);
      check("go_cmd", u_if.cmd, 8'h45);
      u_if.clr_cmd_rdy = 1'b1;
      tick();
      u_if.clr_cmd_rdy = 1'b0;
      check("go_gap", u_if.cmd_rdy, 1'b0);
      tick();
      tick();

      // Simultaneous remote/local from fresh reset
      do_reset();
      u_if.rmt_cmd = 8'h41;
      u_if.rmt_rdy = 1'b1;
      u_if.lcl_cmd = 8'h42;
      u_if.lcl_rdy = 1'b1;
      tick();
      check("rr_clr_rmt", u_if.clr_rmt_rdy, 1'b1);
      check("rr_clr_lcl0", u_if.clr_lcl_rdy, 1'b0);
      u_if.rmt_rdy = 1'b0;
      tick();
      check("rr_clr_lcl", u_if.clr_lcl_rdy, 1'b1);
      check("rr_rdy1", u_if.cmd_rdy, 1'b1);
      check("rr_cmd1", u_if.cmd, 8'h41);
      u_if.lcl_rdy     = 1'b0;
      u_if.clr_cmd_rdy = 1'b1;
      tick();
      u_if.clr_cmd_rdy = 1'b0;
      check("rr_gap", u_if.cmd_rdy, 1'b0);
      tick();
      check("rr_idle", u_if.cmd_rdy, 1'b0);
      tick();
      check("rr_rdy2", u_if.cmd_rdy, 1'b1);
      check("rr_cmd2", u_if.cmd, 8'h42);
      u_if.clr_cmd_rdy = 1'b1;
      tick();
      u_if.clr_cmd_rdy = 1'b0;
      tick();
      tick();

      // Fill the FIFO behind a held command, then STOP
      send_rmt(8'h51);
      send_rmt(8'h52);
      send_rmt(8'h53);
      send_rmt(8'h54);
      check("fill_not_full", u_if.full, 1'b0);
      send_rmt(8'h55);
      check("fill_full", u_if.full, 1'b1);
      check("fill_cmd", u_if.cmd, 8'h51);
      check("fill_rdy", u_if.cmd_rdy, 1'b1);
      u_if.lcl_cmd = 8'h56;
      u_if.lcl_rdy = 1'b1;
      tick();
      check("fill_reject1", u_if.clr_lcl_rdy, 1'b0);
      tick();
      check("fill_reject2", u_if.clr_lcl_rdy, 1'b0);
      check("fill_still_full", u_if.full, 1'b1);
      u_if.lcl_rdy = 1'b0;
      u_if.rmt_cmd = 8'h00;
      u_if.rmt_rdy = 1'b1;
      tick();
      check("stop_cmd", u_if.cmd, 8'h00);
      check("stop_rdy", u_if.cmd_rdy, 1'b1);
      check("stop_flush", u_if.full, 1'b0);
      check("stop_clr_rmt", u_if.clr_rmt_rdy, 1'b1);
      u_if.rmt_rdy     = 1'b0;
      u_if.clr_cmd_rdy = 1'b1;
      tick();
      u_if.clr_cmd_rdy = 1'b0;
      tick();
      tick();
      check("stop_empty", u_if.cmd_rdy, 1'b0);
      check("stop_hold", u_if.cmd, 8'h00);

      // Invalid opcode from local
      u_if.lcl_cmd = 8'h80;
      u_if.lcl_rdy = 1'b1;
      tick();
      check("bad_drop", u_if.drop, 1'b1);
      check("bad_clr_lcl", u_if.clr_lcl_rdy, 1'b1);
      u_if.lcl_rdy = 1'b0;
      tick();
      check("bad_drop_off", u_if.drop, 1'b0);
      check("bad_clr_off", u_if.clr_lcl_rdy, 1'b0);
      tick();
      check("bad_not_queued", u_if.cmd_rdy, 1'b0);

      // STOP coinciding with clr_cmd_rdy
      send_rmt(8'h47);
      check("sc_go_cmd", u_if.cmd, 8'h47);
      u_if.rmt_cmd     = 8'h00;
      u_if.rmt_rdy     = 1'b1;
      u_if.clr_cmd_rdy = 1'b1;
      tick();
      check("sc_cmd", u_if.cmd, 8'h00);
      check("sc_rdy", u_if.cmd_rdy, 1'b1);
      u_if.rmt_rdy     = 1'b0;
      u_if.clr_cmd_rdy = 1'b0;
      tick();
      check("sc_rdy_hold", u_if.cmd_rdy, 1'b1);
      u_if.clr_cmd_rdy = 1'b1;
      tick();
      u_if.clr_cmd_rdy = 1'b0;
      tick();
      tick();

      // Asynchronous reset mid-queue
      send_rmt(8'h61);
      send_rmt(8'h62);
      send_rmt(8'h63);
      check("ar_rdy_before", u_if.cmd_rdy, 1'b1);
      #2 rst_n = 1'b0;
      u_if.rmt_cmd = 8'h64;
      u_if.rmt_rdy = 1'b1;
      #1;
      check("ar_cmd", u_if.cmd, 8'h00);
      check("ar_rdy", u_if.cmd_rdy, 1'b0);
      check("ar_clr_rmt", u_if.clr_rmt_rdy, 1'b0);
      check("ar_clr_lcl", u_if.clr_lcl_rdy, 1'b0);
      check("ar_drop", u_if.drop, 1'b0);
      check("ar_full", u_if.full, 1'b0);
      #2 rst_n = 1'b1;
      tick();
      check("ar_reaccept", u_if.clr_rmt_rdy, 1'b1);
      u_if.rmt_rdy = 1'b0;
      tick();
      check("ar_new_cmd", u_if.cmd, 8'h64);
      check("ar_new_rdy", u_if.cmd_rdy, 1'b1);
      u_if.clr_cmd_rdy = 1'b1;
      tick();
      u_if.clr_cmd_rdy = 1'b0;
      tick();
      tick();
      check("ar_fifo_empty", u_if.cmd_rdy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
